// File: rtl/gat_bram_load_bridge_pkg.sv
// Shared FSM encodings and beat-width helper for the PS->accelerator BRAM load bridge.
package gat_bram_load_bridge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_KICK = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    function automatic int beats_w(input int beats);
        return (beats <= 1) ? 0 : $clog2(beats);
    endfunction

endpackage

// File: rtl/gat_bram_pack_ch.sv
// One load channel: checks beat order, packs BEATS PS beats into one target word and
// counts words against the armed length. Target write lands one cycle after the last beat.
module gat_bram_pack_ch
    import gat_bram_load_bridge_pkg::*;
#(
    parameter int TOP_WIDTH  = 32,
    parameter int TGT_WIDTH  = 64,
    parameter int BEATS      = 2,
    parameter int TGT_ADDR_W = 18,
    parameter int CNT_W      = 19,
    parameter int AW         = TGT_ADDR_W + beats_w(BEATS) + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arm_i,
    input  logic                  en_i,
    input  logic [CNT_W-1:0]      len_i,
    input  logic                  load_i,
    input  logic [TOP_WIDTH-1:0]  ps_din_i,
    input  logic                  ps_ena_i,
    input  logic                  ps_wea_i,
    input  logic [AW-1:0]         ps_addra_i,
    output logic                  tgt_we_o,
    output logic [TGT_ADDR_W-1:0] tgt_addr_o,
    output logic [TGT_WIDTH-1:0]  tgt_din_o,
    output logic                  armed_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int BW = beats_w(BEATS);
    localparam int PW = (BW > 0) ? BW : 1;
    localparam int FW = TOP_WIDTH * BEATS;

    logic                  armed_q, done_q, err_q, we_q;
    logic [CNT_W-1:0]      len_q, cnt_q;
    logic [PW-1:0]         ptr_q;
    logic [FW-1:0]         part_q;
    logic [TGT_ADDR_W-1:0] addr_q;
    logic [TGT_WIDTH-1:0]  din_q;

    logic [TGT_ADDR_W+BW-1:0] word_addr;
    logic [TGT_ADDR_W-1:0]    taddr;
    logic [PW-1:0]            beat;
    logic [FW-1:0]            full;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     accept, last;
    logic                     unused_addr_lsbs;

    assign word_addr        = ps_addra_i[AW-1:2];
    assign taddr            = word_addr[TGT_ADDR_W+BW-1:BW];
    assign unused_addr_lsbs = ^ps_addra_i[1:0];

    if (BW > 0) begin : g_beat
        assign beat = word_addr[PW-1:0];
    end else begin : g_nobeat
        assign beat = '0;
    end

    assign accept  = load_i & armed_q & ps_ena_i & ps_wea_i;
    assign last    = (ptr_q == PW'(BEATS - 1));
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        full = part_q;
        full[ptr_q*TOP_WIDTH +: TOP_WIDTH] = ps_din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            part_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (arm_i) begin
                armed_q <= en_i;
                len_q   <= len_i;
                cnt_q   <= '0;
                ptr_q   <= '0;
                part_q  <= '0;
                err_q   <= 1'b0;
                // A zero-length channel has nothing to wait for.
                done_q  <= en_i & (len_i == '0);
            end else if (accept) begin
                if (done_q) begin
                    err_q <= 1'b1;
                end else if (beat != ptr_q) begin
                    err_q  <= 1'b1;
                    ptr_q  <= '0;
                    part_q <= '0;
                end else if (last) begin
                    we_q   <= 1'b1;
                    addr_q <= taddr;
                    din_q  <= full[TGT_WIDTH-1:0];
                    ptr_q  <= '0;
                    part_q <= '0;
                    cnt_q  <= cnt_inc;
                    done_q <= (cnt_inc == len_q);
                end else begin
                    part_q <= full;
                    ptr_q  <= ptr_q + 1'b1;
                end
            end
        end
    end

    assign tgt_we_o   = we_q;
    assign tgt_addr_o = addr_q;
    assign tgt_din_o  = din_q;
    assign armed_o    = armed_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: rtl/gat_bram_load_bridge.sv
// Multi-channel PS BRAM load bridge: per-channel packers plus the load -> start -> done run FSM.
// gat_start is a single-cycle pulse; the FSM waits in RUN until gat_done.
module gat_bram_load_bridge
    import gat_bram_load_bridge_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TOP_WIDTH  = 32,
    parameter int TGT_WIDTH  = 64,
    parameter int BEATS      = 2,
    parameter int TGT_ADDR_W = 18,
    parameter int CNT_W      = 19
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         cfg_start_i,
    input  logic [NUM_CH-1:0]                            cfg_ch_en_i,
    input  logic [NUM_CH*CNT_W-1:0]                      cfg_len_i,
    input  logic [NUM_CH*TOP_WIDTH-1:0]                  ps_din_i,
    input  logic [NUM_CH-1:0]                            ps_ena_i,
    input  logic [NUM_CH-1:0]                            ps_wea_i,
    input  logic [NUM_CH*(TGT_ADDR_W+beats_w(BEATS)+2)-1:0] ps_addra_i,
    output logic [NUM_CH-1:0]                            tgt_we_o,
    output logic [NUM_CH*TGT_ADDR_W-1:0]                 tgt_addr_o,
    output logic [NUM_CH*TGT_WIDTH-1:0]                  tgt_din_o,
    output logic [NUM_CH-1:0]                            ch_done_o,
    output logic [NUM_CH-1:0]                            ch_err_o,
    output logic                                         gat_start_o,
    input  logic                                         gat_done_i,
    output logic                                         gat_ready_o,
    output logic [1:0]                                   dbg_state_o
);
    localparam int AW = TGT_ADDR_W + beats_w(BEATS) + 2;

    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] armed;
    logic              arm, load, all_done;

    assign arm      = (state_q == ST_IDLE) & cfg_start_i;
    assign load     = (state_q == ST_LOAD);
    assign all_done = &(ch_done_o | ~armed);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gat_bram_pack_ch #(
            .TOP_WIDTH (TOP_WIDTH),
            .TGT_WIDTH (TGT_WIDTH),
            .BEATS     (BEATS),
            .TGT_ADDR_W(TGT_ADDR_W),
            .CNT_W     (CNT_W),
            .AW        (AW)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .arm_i     (arm),
            .en_i      (cfg_ch_en_i[i]),
            .len_i     (cfg_len_i[i*CNT_W +: CNT_W]),
            .load_i    (load),
            .ps_din_i  (ps_din_i[i*TOP_WIDTH +: TOP_WIDTH]),
            .ps_ena_i  (ps_ena_i[i]),
            .ps_wea_i  (ps_wea_i[i]),
            .ps_addra_i(ps_addra_i[i*AW +: AW]),
            .tgt_we_o  (tgt_we_o[i]),
            .tgt_addr_o(tgt_addr_o[i*TGT_ADDR_W +: TGT_ADDR_W]),
            .tgt_din_o (tgt_din_o[i*TGT_WIDTH +: TGT_WIDTH]),
            .armed_o   (armed[i]),
            .done_o    (ch_done_o[i]),
            .err_o     (ch_err_o[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_start_i) state_d = ST_LOAD;
            ST_LOAD: if (all_done)    state_d = ST_KICK;
            ST_KICK:                  state_d = ST_RUN;
            default: if (gat_done_i)  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign gat_start_o = (state_q == ST_KICK);
    assign gat_ready_o = (state_q == ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Directed bench for gat_bram_load_bridge with default parameters (4 ch, 2 beats of 32b -> 64b).
module tb_gat_bram_load_bridge;
    localparam int NC = 4;
    localparam int AW = 21;
    localparam int CW = 19;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_start;
    logic [NC-1:0]  cfg_ch_en;
    logic [NC*CW-1:0] cfg_len;
    logic [NC*32-1:0] ps_din;
    logic [NC-1:0]  ps_ena, ps_wea;
    logic [NC*AW-1:0] ps_addra;
    logic [NC-1:0]  tgt_we;
    logic [NC*18-1:0] tgt_addr;
    logic [NC*64-1:0] tgt_din;
    logic [NC-1:0]  ch_done, ch_err;
    logic           gat_start, gat_done, gat_ready;
    logic [1:0]     dbg_state;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    gat_bram_load_bridge dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_start_i(cfg_start),
        .cfg_ch_en_i(cfg_ch_en),
        .cfg_len_i  (cfg_len),
        .ps_din_i   (ps_din),
        .ps_ena_i   (ps_ena),
        .ps_wea_i   (ps_wea),
        .ps_addra_i (ps_addra),
        .tgt_we_o   (tgt_we),
        .tgt_addr_o (tgt_addr),
        .tgt_din_o  (tgt_din),
        .ch_done_o  (ch_done),
        .ch_err_o   (ch_err),
        .gat_start_o(gat_start),
        .gat_done_i (gat_done),
        .gat_ready_o(gat_ready),
        .dbg_state_o(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] en, input int l0, input int l1, input int l2, input int l3);
        cfg_ch_en = en;
        cfg_len   = {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Channel c receives data base + c*16 at the given byte address.
    task automatic beats(input logic [3:0] mask, input logic [AW-1:0] addr, input logic [31:0] base);
        for (int c = 0; c < NC; c++) begin
            ps_din[c*32 +: 32]   = base + 32'(c * 16);
            ps_addra[c*AW +: AW] = addr;
        end
        ps_ena = mask;
        ps_wea = mask;
        tick();
        ps_ena = '0;
        ps_wea = '0;
    endtask

    task automatic complete_run();
        tick();
        chk("kick_state", 64'(dbg_state), 64'd2);
        chk("kick_pulse", 64'(gat_start), 64'd1);
        tick();
        chk("run_state", 64'(dbg_state), 64'd3);
        chk("pulse_one_cycle", 64'(gat_start), 64'd0);
        gat_done = 1'b1;
        tick();
        gat_done = 1'b0;
        chk("back_idle", 64'(dbg_state), 64'd0);
        chk("ready_after_done", 64'(gat_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_ch_en = '0; cfg_len = '0;
        ps_din = '0; ps_ena = '0; ps_wea = '0; ps_addra = '0; gat_done = 1'b0;
        tick(); tick(); tick();

        // 1: reset state
        chk("rst_ready", 64'(gat_ready), 64'd1);
        chk("rst_we", 64'(tgt_we), 64'd0);
        chk("rst_done", 64'(ch_done), 64'd0);
        chk("rst_err", 64'(ch_err), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_start", 64'(gat_start), 64'd0);
        rst = 1'b0;
        tick();

        // 2: two words on ch0
        start(4'b0001, 2, 0, 0, 0);
        chk("t2_load_state", 64'(dbg_state), 64'd1);
        chk("t2_not_ready", 64'(gat_ready), 64'd0);
        beats(4'b0001, 21'h0, 32'hAAAA0001);
        chk("t2_no_we_half", 64'(tgt_we), 64'd0);
        beats(4'b0001, 21'h4, 32'hBBBB0002);
        chk("t2_we0", 64'(tgt_we), 64'd1);
        chk("t2_addr0", 64'(tgt_addr[17:0]), 64'd0);
        chk("t2_din0", tgt_din[63:0], 64'hBBBB0002_AAAA0001);
        chk("t2_not_done", 64'(ch_done), 64'd0);
        beats(4'b0001, 21'h8, 32'hCCCC0003);
        chk("t2_we_drop", 64'(tgt_we), 64'd0);
        beats(4'b0001, 21'hC, 32'hDDDD0004);
        chk("t2_we1", 64'(tgt_we), 64'd1);
        chk("t2_addr1", 64'(tgt_addr[17:0]), 64'd1);
        chk("t2_din1", tgt_din[63:0], 64'hDDDD0004_CCCC0003);
        chk("t2_done", 64'(ch_done), 64'd1);
        complete_run();

        // 3: out-of-order beat
        start(4'b0001, 1, 0, 0, 0);
        beats(4'b0001, 21'h4, 32'h0000EEEE);
        chk("t3_err", 64'(ch_err), 64'd1);
        chk("t3_no_we", 64'(tgt_we), 64'd0);
        beats(4'b0001, 21'h0, 32'h12345678);
        chk("t3_no_we2", 64'(tgt_we), 64'd0);
        beats(4'b0001, 21'h4, 32'h9ABCDEF0);
        chk("t3_we", 64'(tgt_we), 64'd1);
        chk("t3_addr", 64'(tgt_addr[17:0]), 64'd0);
        chk("t3_din", tgt_din[63:0], 64'h9ABCDEF0_12345678);
        chk("t3_err_sticky", 64'(ch_err), 64'd1);
        complete_run();

        // 4: ch0/ch2 enabled; start ignored in RUN; gat_done+cfg_start together
        start(4'b0101, 1, 0, 1, 0);
        chk("t4_err_clear", 64'(ch_err), 64'd0);
        chk("t4_done_clear", 64'(ch_done), 64'd0);
        beats(4'b0001, 21'h10, 32'h01010100);
        beats(4'b0001, 21'h14, 32'h02020200);
        chk("t4_addr0", 64'(tgt_addr[17:0]), 64'd2);
        chk("t4_din0", tgt_din[63:0], 64'h02020200_01010100);
        chk("t4_wait_ch2", 64'(dbg_state), 64'd1);
        tick();
        chk("t4_still_load", 64'(dbg_state), 64'd1);
        beats(4'b0100, 21'h0, 32'h03030300);
        beats(4'b0100, 21'h4, 32'h04040400);
        chk("t4_we2", 64'(tgt_we), 64'b0100);
        chk("t4_din2", tgt_din[2*64 +: 64], 64'h04040420_03030320);
        chk("t4_done", 64'(ch_done), 64'b0101);
        tick();
        chk("t4_kick", 64'(dbg_state), 64'd2);
        chk("t4_pulse", 64'(gat_start), 64'd1);
        tick();
        chk("t4_run", 64'(dbg_state), 64'd3);
        chk("t4_pulse_off", 64'(gat_start), 64'd0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("t4_start_in_run", 64'(dbg_state), 64'd3);
        chk("t4_run_not_ready", 64'(gat_ready), 64'd0);
        cfg_start = 1'b1;
        gat_done  = 1'b1;
        tick();
        cfg_start = 1'b0;
        gat_done  = 1'b0;
        chk("t4_done_wins", 64'(dbg_state), 64'd0);
        chk("t4_ready", 64'(gat_ready), 64'd1);
        chk("t4_flags_held", 64'(ch_done), 64'b0101);

        // 5: all channels in the same cycle; overrun after done
        start(4'b1111, 1, 1, 1, 2);
        beats(4'b1111, 21'h0, 32'h50000000);
        chk("t5_no_we", 64'(tgt_we), 64'd0);
        beats(4'b1111, 21'h4, 32'h50000001);
        chk("t5_we_all", 64'(tgt_we), 64'b1111);
        for (int c = 0; c < NC; c++) begin
            logic [31:0] b0, b1;
            b0 = 32'h50000000 + 32'(c * 16);
            b1 = b0 + 32'd1;
            chk($sformatf("t5_din%0d", c), tgt_din[c*64 +: 64], {b1, b0});
        end
        chk("t5_done", 64'(ch_done), 64'b0111);
        beats(4'b0001, 21'h8, 32'h0BAD0000);
        chk("t5_overrun_err", 64'(ch_err), 64'b0001);
        chk("t5_overrun_no_we", 64'(tgt_we), 64'd0);
        beats(4'b1000, 21'h8, 32'h70000000);
        beats(4'b1000, 21'hC, 32'h71000000);
        chk("t5_we3", 64'(tgt_we), 64'b1000);
        chk("t5_addr3", 64'(tgt_addr[3*18 +: 18]), 64'd1);
        chk("t5_din3", tgt_din[3*64 +: 64], 64'h71000030_70000030);
        chk("t5_done_all", 64'(ch_done), 64'b1111);
        complete_run();

        // zero-length channel and empty enable mask
        start(4'b0001, 0, 0, 0, 0);
        chk("len0_done", 64'(ch_done), 64'd1);
        complete_run();
        start(4'b0000, 0, 0, 0, 0);
        chk("en0_load", 64'(dbg_state), 64'd1);
        complete_run();

        // 6: reset mid-load drops the partial word
        start(4'b0001, 1, 0, 0, 0);
        beats(4'b0001, 21'h0, 32'hDEAD0000);
        rst = 1'b1;
        tick();
        chk("t6_rst_we", 64'(tgt_we), 64'd0);
        chk("t6_rst_state", 64'(dbg_state), 64'd0);
        chk("t6_rst_ready", 64'(gat_ready), 64'd1);
        rst = 1'b0;
        tick();
        chk("t6_idle_we", 64'(tgt_we), 64'd0);
        start(4'b0001, 1, 0, 0, 0);
        beats(4'b0001, 21'h0, 32'h00000111);
        chk("t6_half_no_we", 64'(tgt_we), 64'd0);
        beats(4'b0001, 21'h4, 32'h00000222);
        chk("t6_we", 64'(tgt_we), 64'd1);
        chk("t6_din", tgt_din[63:0], 64'h00000222_00000111);
        chk("t6_done", 64'(ch_done), 64'd1);
        complete_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
